// File: rtl/sd_defs.sv
// Shared SD SPI-mode definitions: command bytes, tokens, data-response codes
// and the single-block writer state encoding.
package sd_defs;

  localparam logic [7:0] CMD17       = 8'h51;
  localparam logic [7:0] CMD24       = 8'h58;
  localparam logic [7:0] START_TOKEN = 8'hFE;

  localparam logic [2:0] DRESP_ACCEPT = 3'b010;
  localparam logic [2:0] DRESP_CRC    = 3'b101;
  localparam logic [2:0] DRESP_WERR   = 3'b110;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_CMD_RESP,
    ST_GAP,
    ST_TOKEN,
    ST_DATA,
    ST_CRC,
    ST_DRESP,
    ST_BUSY,
    ST_DONE,
    ST_FAIL
  } wr_state_t;

  // Command frame as it goes on the wire: command byte, argument, dummy CRC.
  function automatic logic [47:0] cmd_frame(input logic [7:0] cmd, input logic [31:0] arg);
    return {cmd, arg, 8'hFF};
  endfunction

  function automatic logic [15:0] sat_dec(input logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : v - 16'd1;
  endfunction

endpackage

// File: rtl/sd_byte_tx.sv
// Negedge MSB-first byte shifter for the SD MOSI line. Flags the LSB period
// and raises a one-period byte request while the LSB is on the wire.
module sd_byte_tx (
  input  logic       i_clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_shift,
  input  logic       i_req_en,
  input  logic [7:0] i_data,
  output logic       o_bit,
  output logic       o_last,
  output logic       o_wr_req
);

  logic [7:0] r_sh;
  logic [2:0] r_idx;
  logic       r_wr_req;

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(negedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh     <= 8'hFF;
      r_idx    <= 3'd0;
      r_wr_req <= 1'b0;
    end else begin
      r_wr_req <= 1'b0;
      if (i_load) begin
        r_sh  <= i_data;
        r_idx <= 3'd0;
      end else if (i_shift) begin
        r_sh     <= {r_sh[6:0], 1'b1};
        r_idx    <= r_idx + 3'd1;
        // Request rises together with the LSB so the source has a full period.
        r_wr_req <= i_req_en && (r_idx == 3'd6);
      end
    end
  end

  assign o_bit    = r_sh[7];
  assign o_last   = (r_idx == 3'd7);
  assign o_wr_req = r_wr_req;

endmodule

// File: rtl/sd_write.sv
// SPI-mode SD single-block writer: CMD24, start token, data block, dummy CRC,
// data-response check and busy wait. MOSI/state on negedge, MISO on posedge.
module sd_write
  import sd_defs::*;
#(
  parameter int BLOCK_BYTES   = 512,
  parameter int RESP_TIMEOUT  = 128,
  parameter int DRESP_TIMEOUT = 16,
  parameter int BUSY_TIMEOUT  = 65535
) (
  input  logic        SD_CK,
  input  logic        rst_n,
  input  logic        init_o,
  input  logic        write_seq,
  input  logic [31:0] addr,
  input  logic [7:0]  wr_data,
  output logic        wr_req,
  input  logic        SD_MISO,
  output logic        SD_MOSI,
  output logic        SD_CSn,
  output logic        busy,
  output logic        ok,
  output logic        err
);

  localparam logic [9:0]  LP_BLOCK = 10'(BLOCK_BYTES);
  localparam logic [15:0] LP_RESP  = 16'(RESP_TIMEOUT);
  localparam logic [15:0] LP_DRESP = 16'(DRESP_TIMEOUT);
  localparam logic [15:0] LP_BUSY  = 16'(BUSY_TIMEOUT);

  wr_state_t   r_state;
  logic [47:0] r_frame;
  logic [5:0]  r_bit_cnt;
  logic [9:0]  r_byte_cnt;
  logic [15:0] r_tmo;
  logic [2:0]  r_tok;
  logic [7:0]  r_rx;
  logic        r_csn;
  logic        r_mosi;
  logic        r_use_tx;
  logic        r_busy;
  logic        r_ok;
  logic        r_err;

  logic       w_tx_load;
  logic       w_tx_shift;
  logic       w_req_en;
  logic [7:0] w_tx_data;
  logic       w_tx_bit;
  logic       w_tx_last;
  logic       w_tx_wr_req;

  always_ff @(posedge SD_CK or negedge rst_n) begin
    if (!rst_n) r_rx <= 8'h00;
    else        r_rx <= {r_rx[6:0], SD_MISO};
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_tx_load  = 1'b0;
    w_tx_shift = 1'b0;
    w_tx_data  = 8'hFF;
    w_req_en   = (r_state == ST_TOKEN) ||
                 ((r_state == ST_DATA) && (r_byte_cnt != LP_BLOCK));
    case (r_state)
      ST_CMD_RESP: w_tx_load = (r_rx == 8'h00);
      ST_GAP, ST_TOKEN, ST_DATA, ST_CRC: begin
        if (!w_tx_last) begin
          w_tx_shift = 1'b1;
        end else begin
          case (r_state)
            ST_GAP: begin
              w_tx_load = 1'b1;
              w_tx_data = START_TOKEN;
            end
            ST_TOKEN: begin
              w_tx_load = 1'b1;
              w_tx_data = wr_data;
            end
            ST_DATA: begin
              w_tx_load = 1'b1;
              w_tx_data = (r_byte_cnt == LP_BLOCK) ? 8'hFF : wr_data;
            end
            default: w_tx_load = (r_byte_cnt == 10'd0);
          endcase
        end
      end
      default: ;
    endcase
  end

  sd_byte_tx u_tx (
    .i_clk    (SD_CK),
    .rst_n    (rst_n),
    .i_load   (w_tx_load),
    .i_shift  (w_tx_shift),
    .i_req_en (w_req_en),
    .i_data   (w_tx_data),
    .o_bit    (w_tx_bit),
    .o_last   (w_tx_last),
    .o_wr_req (w_tx_wr_req)
  );

  always_ff @(negedge SD_CK or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_frame    <= 48'hFFFF_FFFF_FFFF;
      r_bit_cnt  <= 6'd0;
      r_byte_cnt <= 10'd0;
      r_tmo      <= 16'd0;
      r_tok      <= 3'd0;
      r_csn      <= 1'b1;
      r_mosi     <= 1'b1;
      r_use_tx   <= 1'b0;
      r_busy     <= 1'b0;
      r_ok       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_csn    <= 1'b1;
          r_mosi   <= 1'b1;
          r_use_tx <= 1'b0;
          if (init_o && write_seq) begin
            r_frame   <= cmd_frame(CMD24, addr);
            r_bit_cnt <= 6'd0;
            r_ok      <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= ST_CMD;
          end
        end
        ST_CMD: begin
          r_csn     <= 1'b0;
          r_mosi    <= r_frame[47];
          r_frame   <= {r_frame[46:0], 1'b1};
          r_bit_cnt <= r_bit_cnt + 6'd1;
          if (r_bit_cnt == 6'd47) begin
            r_tmo   <= LP_RESP;
            r_state <= ST_CMD_RESP;
          end
        end
        ST_CMD_RESP: begin
          r_mosi <= 1'b1;
          r_tmo  <= sat_dec(r_tmo);
          if (r_rx == 8'h00) begin
            r_use_tx <= 1'b1;
            r_state  <= ST_GAP;
          end else if (r_tmo <= 16'd1) begin
            r_state <= ST_FAIL;
          end
        end
        ST_GAP: if (w_tx_last) r_state <= ST_TOKEN;
        ST_TOKEN: begin
          if (w_tx_last) begin
            r_byte_cnt <= 10'd1;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tx_last) begin
            if (r_byte_cnt == LP_BLOCK) begin
              r_byte_cnt <= 10'd0;
              r_state    <= ST_CRC;
            end else begin
              r_byte_cnt <= r_byte_cnt + 10'd1;
            end
          end
        end
        ST_CRC: begin
          if (w_tx_last) begin
            if (r_byte_cnt == 10'd0) begin
              r_byte_cnt <= 10'd1;
            end else begin
              r_use_tx  <= 1'b0;
              r_mosi    <= 1'b1;
              r_bit_cnt <= 6'd0;
              r_tmo     <= LP_DRESP;
              r_state   <= ST_DRESP;
            end
          end
        end
        ST_DRESP: begin
          // bit_cnt 0: hunting the start bit; 1..3: status bits; 4: end bit.
          if (r_bit_cnt == 6'd0) begin
            r_tmo <= sat_dec(r_tmo);
            if (!r_rx[0])             r_bit_cnt <= 6'd1;
            else if (r_tmo <= 16'd1)  r_state   <= ST_FAIL;
          end else begin
            r_tok     <= {r_tok[1:0], r_rx[0]};
            r_bit_cnt <= r_bit_cnt + 6'd1;
            if (r_bit_cnt == 6'd4) begin
              if (r_tok == DRESP_ACCEPT) begin
                r_tmo   <= LP_BUSY;
                r_state <= ST_BUSY;
              end else begin
                r_state <= ST_FAIL;
              end
            end
          end
        end
        ST_BUSY: begin
          r_tmo <= sat_dec(r_tmo);
          if (r_rx[0])              r_state <= ST_DONE;
          else if (r_tmo <= 16'd1)  r_state <= ST_FAIL;
        end
        ST_DONE: begin
          r_csn    <= 1'b1;
          r_mosi   <= 1'b1;
          r_use_tx <= 1'b0;
          r_ok     <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        ST_FAIL: begin
          r_csn    <= 1'b1;
          r_mosi   <= 1'b1;
          r_use_tx <= 1'b0;
          r_err    <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign SD_MOSI = r_use_tx ? w_tx_bit : r_mosi;
  assign SD_CSn  = r_csn;
  assign wr_req  = w_tx_wr_req;
  assign busy    = r_busy;
  assign ok      = r_ok;
  assign err     = r_err;

endmodule
